rx_block_sync_descrambler: RTL and testbench



---
 rtl/rx_block_sync_descrambler_if.sv | 39 +++
 rtl/rx_block_sync_descrambler.sv | 186 ++++++++++++++++++
 tb/tb_rx_block_sync_descrambler.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/rx_block_sync_descrambler_if.sv
// RX 64b/66b block bus: gearbox-side input word, descrambled output word,
// lock status and slip request. Optional sync_err_cnt (RX_SYNC_ERR_CNT_EN).
interface rx_block_sync_descrambler_if;
  logic        data_valid;
  logic [1:0]  sync_info;
  logic [0:63] data_in;
  logic [0:63] data_out;
  logic [1:0]  sync_out;
  logic        data_out_valid;
  logic        block_lock;
  logic        slip;
`ifdef RX_SYNC_ERR_CNT_EN
  logic [15:0] sync_err_cnt;

  modport master (
    output data_valid, sync_info, data_in,
    input  data_out, sync_out, data_out_valid,
    input  block_lock, slip, sync_err_cnt
  );

  modport slave (
    input  data_valid, sync_info, data_in,
    output data_out, sync_out, data_out_valid,
    output block_lock, slip, sync_err_cnt
  );
`else
  modport master (
    output data_valid, sync_info, data_in,
    input  data_out, sync_out, data_out_valid,
    input  block_lock, slip
  );

  modport slave (
    input  data_valid, sync_info, data_in,
    output data_out, sync_out, data_out_valid,
    output block_lock, slip
  );
`endif
endinterface

// File: rtl/rx_block_sync_descrambler.sv
// 64b/66b RX block lock (HUNT/SLIP_WAIT/LOCKED) + x^58+x^39+1 descrambler.
// Ports: clk, reset (async, active-high), bus (slave): data_valid,
// sync_info, data_in in; data_out, sync_out, data_out_valid, block_lock,
// slip out. Define RX_SYNC_ERR_CNT_EN to add bus.sync_err_cnt.
module rx_block_sync_descrambler #(
  parameter int RX_DATA_WIDTH    = 64,
  parameter int LOCK_COUNT       = 64,
  parameter int BAD_LIMIT        = 16,
  parameter int SLIP_WAIT_CYCLES = 32
) (
  input logic clk,
  input logic reset,
  rx_block_sync_descrambler_if.slave bus
);
  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam int BW = $clog2(BAD_LIMIT + 1);
  localparam int WW = $clog2(SLIP_WAIT_CYCLES + 1);

  localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_COUNT - 1);
  localparam logic [GW-1:0] WIN_LAST  = GW'(LOCK_COUNT);
  localparam logic [BW-1:0] BAD_LAST  = BW'(BAD_LIMIT);
  localparam logic [WW-1:0] WAIT_LAST = WW'(SLIP_WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    HUNT,
    SLIP_WAIT,
    LOCKED
  } state_e;

  state_e state_q, state_d;
  logic [GW-1:0] good_cnt_q, good_cnt_d;
  logic [GW-1:0] win_cnt_q, win_cnt_d;
  logic [BW-1:0] bad_cnt_q, bad_cnt_d;
  logic [WW-1:0] wait_cnt_q, wait_cnt_d;
  logic [57:0] scr_q, scr_d;
  logic [0:RX_DATA_WIDTH-1] data_out_q, data_out_d;
  logic [1:0] sync_out_q, sync_out_d;
  logic dout_vld_q, dout_vld_d;
  logic block_lock_q, block_lock_d;
  logic slip_q, slip_d;
`ifdef RX_SYNC_ERR_CNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;
`endif

  logic [57:0] scr_nxt;
  logic [0:RX_DATA_WIDTH-1] descr;
  logic good_hdr;
  logic [GW-1:0] win_n;
  logic [BW-1:0] bad_n;

  // Self-synchronizing: the received (scrambled) bit enters the register.
  always_comb begin
    scr_nxt = scr_q;
    descr   = '0;
    for (int i = 0; i < RX_DATA_WIDTH; i++) begin
      descr[i] = bus.data_in[i] ^ scr_nxt[38] ^ scr_nxt[57];
      scr_nxt  = {scr_nxt[56:0], bus.data_in[i]};
    end
  end

  assign good_hdr = bus.sync_info[1] ^ bus.sync_info[0];
  assign win_n    = win_cnt_q + 1'b1;
  assign bad_n    = bad_cnt_q + BW'(!good_hdr);

  always_comb begin
    state_d    = state_q;
    good_cnt_d = good_cnt_q;
    win_cnt_d  = win_cnt_q;
    bad_cnt_d  = bad_cnt_q;
    wait_cnt_d = wait_cnt_q;
    scr_d      = scr_q;
    data_out_d = data_out_q;
    sync_out_d = sync_out_q;
    dout_vld_d = 1'b0;
    slip_d     = 1'b0;
`ifdef RX_SYNC_ERR_CNT_EN
    err_cnt_d  = err_cnt_q;
`endif

    if (bus.data_valid) scr_d = scr_nxt;

    if (bus.data_valid && state_q == LOCKED) begin
      data_out_d = descr;
      sync_out_d = bus.sync_info;
      dout_vld_d = 1'b1;
    end

    unique case (1'b1)
      (state_q == HUNT): begin
        if (bus.data_valid) begin
          if (good_hdr) begin
            if (good_cnt_q == GOOD_LAST) begin
              state_d    = LOCKED;
              good_cnt_d = '0;
              win_cnt_d  = '0;
              bad_cnt_d  = '0;
            end else begin
              good_cnt_d = good_cnt_q + 1'b1;
            end
          end else begin
            slip_d     = 1'b1;
            state_d    = SLIP_WAIT;
            good_cnt_d = '0;
            wait_cnt_d = '0;
          end
        end
      end
      (state_q == SLIP_WAIT): begin
        if (wait_cnt_q == WAIT_LAST) begin
          state_d    = HUNT;
          wait_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      (state_q == LOCKED): begin
        if (bus.data_valid) begin
`ifdef RX_SYNC_ERR_CNT_EN
          if (!good_hdr && err_cnt_q != 16'hFFFF)
            err_cnt_d = err_cnt_q + 1'b1;
`endif
          // Unlock takes priority over the window close.
          if (bad_n == BAD_LAST) begin
            slip_d     = 1'b1;
            state_d    = SLIP_WAIT;
            win_cnt_d  = '0;
            bad_cnt_d  = '0;
            wait_cnt_d = '0;
          end else if (win_n == WIN_LAST) begin
            win_cnt_d = '0;
            bad_cnt_d = '0;
          end else begin
            win_cnt_d = win_n;
            bad_cnt_d = bad_n;
          end
        end
      end
      default: state_d = HUNT;
    endcase

    block_lock_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= HUNT;
      good_cnt_q   <= '0;
      win_cnt_q    <= '0;
      bad_cnt_q    <= '0;
      wait_cnt_q   <= '0;
      scr_q        <= '1;
      data_out_q   <= '0;
      sync_out_q   <= '0;
      dout_vld_q   <= 1'b0;
      block_lock_q <= 1'b0;
      slip_q       <= 1'b0;
`ifdef RX_SYNC_ERR_CNT_EN
      err_cnt_q    <= '0;
`endif
    end else begin
      state_q      <= state_d;
      good_cnt_q   <= good_cnt_d;
      win_cnt_q    <= win_cnt_d;
      bad_cnt_q    <= bad_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
      scr_q        <= scr_d;
      data_out_q   <= data_out_d;
      sync_out_q   <= sync_out_d;
      dout_vld_q   <= dout_vld_d;
      block_lock_q <= block_lock_d;
      slip_q       <= slip_d;
`ifdef RX_SYNC_ERR_CNT_EN
      err_cnt_q    <= err_cnt_d;
`endif
    end
  end

  assign bus.data_out       = data_out_q;
  assign bus.sync_out       = sync_out_q;
  assign bus.data_out_valid = dout_vld_q;
  assign bus.block_lock     = block_lock_q;
  assign bus.slip           = slip_q;
`ifdef RX_SYNC_ERR_CNT_EN
  assign bus.sync_err_cnt   = err_cnt_q;
`endif
endmodule

// File: tb/tb_rx_block_sync_descrambler.sv
// Directed bench for rx_block_sync_descrambler: lock, descramble,
// hunt slip, lock loss, data_valid gaps, async reset, optional err count.
module tb_rx_block_sync_descrambler;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  rx_block_sync_descrambler_if bus();

  rx_block_sync_descrambler dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_pass = 0;
  int slips = 0;
  int base;
  logic [57:0] tx_s;

  localparam logic [63:0] P1 = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] P2 = 64'hDEAD_BEEF_F00D_CAFE;
  localparam logic [63:0] P3 = 64'hA5A5_0000_FFFF_5A5A;
  localparam logic [63:0] P4 = 64'h8000_0000_0000_0001;

  always @(negedge clk) if (bus.slip) slips++;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // TX-side scrambler model: the scrambled output bit is fed back.
  task automatic step(input logic v, input logic [1:0] h,
                      input logic [63:0] p);
    logic [0:63] pp;
    logic [0:63] o;
    pp = p;
    o = '0;
    if (v) begin
      for (int i = 0; i < 64; i++) begin
        o[i] = pp[i] ^ tx_s[38] ^ tx_s[57];
        tx_s = {tx_s[56:0], o[i]};
      end
    end
    bus.data_valid = v;
    bus.sync_info  = h;
    bus.data_in    = o;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.data_valid = 1'b0;
    bus.sync_info  = 2'b00;
    bus.data_in    = '0;
    tx_s = '1;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    do_reset();
    chk("rst_lock", 64'(bus.block_lock), 64'd0);
    chk("rst_slip", 64'(bus.slip), 64'd0);
    chk("rst_dov", 64'(bus.data_out_valid), 64'd0);
    chk("rst_data", 64'(bus.data_out), 64'd0);
    chk("rst_sync", 64'(bus.sync_out), 64'd0);

    // Lock acquisition
    repeat (63) step(1'b1, 2'b01, 64'd0);
    chk("pre_lock", 64'(bus.block_lock), 64'd0);
    step(1'b1, 2'b01, 64'd0);
    chk("lock", 64'(bus.block_lock), 64'd1);
    chk("lock_dov", 64'(bus.data_out_valid), 64'd0);
    chk("lock_noslip", 64'(slips), 64'd0);
    step(1'b1, 2'b10, P1);
    chk("w65_dov", 64'(bus.data_out_valid), 64'd1);
    chk("w65_data", 64'(bus.data_out), P1);
    chk("w65_sync", 64'(bus.sync_out), 64'd2);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 2'b01, 64'd0);
      chk("zero_data", 64'(bus.data_out), 64'd0);
    end
    step(1'b1, 2'b01, P2);
    chk("p2_data", 64'(bus.data_out), P2);
    step(1'b0, 2'b11, 64'd0);
    chk("gap_dov", 64'(bus.data_out_valid), 64'd0);
    chk("gap_hold", 64'(bus.data_out), P2);

    // Window 1: 15 bad at its end, window 2: 16 bad
    repeat (43) step(1'b1, 2'b01, 64'd0);
    repeat (15) step(1'b1, 2'b00, 64'd0);
    chk("w1_15bad", 64'(bus.block_lock), 64'd1);
    repeat (15) step(1'b1, 2'b11, 64'd0);
    chk("w2_15bad", 64'(bus.block_lock), 64'd1);
    chk("w2_dov", 64'(bus.data_out_valid), 64'd1);
    step(1'b1, 2'b00, 64'd0);
    chk("unlock", 64'(bus.block_lock), 64'd0);
    chk("unlock_slip", 64'(bus.slip), 64'd1);
    step(1'b0, 2'b00, 64'd0);
    chk("unlock_slip_end", 64'(bus.slip), 64'd0);
    chk("unlock_slips", 64'(slips), 64'd1);

    // Hunt slip
    do_reset();
    base = slips;
    repeat (9) step(1'b1, 2'b10, 64'd0);
    step(1'b1, 2'b11, 64'd0);
    chk("hunt_slip", 64'(bus.slip), 64'd1);
    step(1'b1, 2'b11, 64'd0);
    chk("hunt_slip_end", 64'(bus.slip), 64'd0);
    repeat (31) step(1'b1, 2'b11, 64'd0);
    chk("hunt_one_slip", 64'(slips - base), 64'd1);
    repeat (63) step(1'b1, 2'b01, 64'd0);
    chk("relock_pre", 64'(bus.block_lock), 64'd0);
    step(1'b1, 2'b01, 64'd0);
    chk("relock", 64'(bus.block_lock), 64'd1);
    step(1'b1, 2'b01, P3);
    chk("relock_data", 64'(bus.data_out), P3);
    chk("relock_slips", 64'(slips - base), 64'd1);
`ifdef RX_SYNC_ERR_CNT_EN
    chk("err_hunt", 64'(bus.sync_err_cnt), 64'd0);
`endif

    // Gaps in data_valid
    do_reset();
    for (int i = 0; i < 64; i++) begin
      step(1'b1, 2'b10, 64'd0);
      if (i == 62) chk("gap_pre_lock", 64'(bus.block_lock), 64'd0);
      if (i == 63) chk("gap_lock", 64'(bus.block_lock), 64'd1);
      step(1'b0, 2'b00, 64'd0);
    end
    repeat (3) step(1'b1, 2'b00, 64'd0);
`ifdef RX_SYNC_ERR_CNT_EN
    chk("err_cnt3", 64'(bus.sync_err_cnt), 64'd3);
`endif
    chk("bad3_lock", 64'(bus.block_lock), 64'd1);
    step(1'b1, 2'b01, P4);
    chk("p4_data", 64'(bus.data_out), P4);
    chk("p4_dov", 64'(bus.data_out_valid), 64'd1);

    // Asynchronous reset mid-window, between clock edges
    #3 reset = 1'b1;
    #1;
    chk("arst_lock", 64'(bus.block_lock), 64'd0);
    chk("arst_dov", 64'(bus.data_out_valid), 64'd0);
    chk("arst_data", 64'(bus.data_out), 64'd0);
    chk("arst_sync", 64'(bus.sync_out), 64'd0);
    chk("arst_slip", 64'(bus.slip), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
